pipe_mult_hs: RTL and testbench

- Parametrised pipelined shift-add multiplier; successor to the single-stage multiply cell in the pipeline_multiply area.
- Processes BPS multiplier bits per stage, so there are M/BPS stages.
- Adds per-transaction signed/unsigned mode, a valid/ready handshake with backpressure, a tag passthrough and a synchronous flush.
- Sits between an operand producer and a result consumer in datapath blocks.

---
 rtl/pipe_mult_hs_if.sv | 28 ++
 rtl/pipe_mult_hs.sv | 108 ++++++++++
 tb/tb_pipe_mult_hs.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_mult_hs_if.sv
// rtl/pipe_mult_hs_if.sv - operand/result handshake bundle for pipe_mult_hs
interface pipe_mult_hs_if #(
  parameter int N     = 8,
  parameter int M     = 8,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [N-1:0]     in_a;
  logic [M-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [N+M-1:0]   out_p;
  logic [TAG_W-1:0] out_tag;
  logic             out_signed;

  modport slave (
    input  in_valid, in_signed, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_tag, out_signed
  );

  modport master (
    output in_valid, in_signed, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_tag, out_signed
  );
endinterface

// File: rtl/pipe_mult_hs.sv
// rtl/pipe_mult_hs.sv - pipelined shift-add multiplier, BPS multiplier bits per stage
// Rank 0 holds the prepared operands; ranks 1..S each add one stage of partial products.
module pipe_mult_hs #(
  parameter int N     = 8,
  parameter int M     = 8,
  parameter int BPS   = 1,
  parameter int TAG_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  pipe_mult_hs_if.slave bus
);
  localparam int S = (BPS >= 1) ? (M / BPS) : 1;
  localparam int W = N + M;

  if (BPS < 1 || (M % BPS) != 0) begin : g_bad_bps
    $error("pipe_mult_hs: BPS must be >= 1 and divide M");
  end

  logic             vld_q [0:S];
  logic             vld_d [0:S];
  logic             sgn_q [0:S];
  logic             sgn_d [0:S];
  logic [TAG_W-1:0] tag_q [0:S];
  logic [TAG_W-1:0] tag_d [0:S];
  logic [W-1:0]     acc_q [0:S];
  logic [W-1:0]     acc_d [0:S];
  logic [W-1:0]     a_q   [0:S-1];
  logic [W-1:0]     a_d   [0:S-1];
  logic [M-1:0]     b_q   [0:S-1];
  logic [M-1:0]     b_d   [0:S-1];

  logic         adv;
  logic [W-1:0] a_ext;
  logic [W-1:0] sum;
  logic [W-1:0] pp;

  always_comb begin
    adv   = !vld_q[S] || bus.out_ready;
    a_ext = bus.in_signed ? {{M{bus.in_a[N-1]}}, bus.in_a} : {{M{1'b0}}, bus.in_a};
    vld_d = vld_q;
    sgn_d = sgn_q;
    tag_d = tag_q;
    acc_d = acc_q;
    a_d   = a_q;
    b_d   = b_q;
    sum   = '0;
    pp    = '0;
    if (flush) begin
      for (int k = 0; k <= S; k++) vld_d[k] = 1'b0;
    end else if (adv) begin
      vld_d[0] = bus.in_valid;
      sgn_d[0] = bus.in_signed;
      tag_d[0] = bus.in_tag;
      acc_d[0] = '0;
      a_d[0]   = a_ext;
      b_d[0]   = bus.in_b;
      for (int k = 0; k < S; k++) begin
        sum = acc_q[k];
        for (int i = 0; i < BPS; i++) begin
          pp = a_q[k] << (k * BPS + i);
          // The multiplier MSB carries negative weight in two's complement
          if (b_q[k][k * BPS + i]) begin
            if (sgn_q[k] && (k * BPS + i == M - 1)) sum = sum - pp;
            else                                    sum = sum + pp;
          end
        end
        vld_d[k+1] = vld_q[k];
        sgn_d[k+1] = sgn_q[k];
        tag_d[k+1] = tag_q[k];
        acc_d[k+1] = sum;
      end
      for (int k = 1; k < S; k++) begin
        a_d[k] = a_q[k-1];
        b_d[k] = b_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= S; k++) begin
        vld_q[k] <= 1'b0;
        sgn_q[k] <= 1'b0;
        tag_q[k] <= '0;
        acc_q[k] <= '0;
      end
      for (int k = 0; k < S; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      sgn_q <= sgn_d;
      tag_q <= tag_d;
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  assign bus.in_ready   = adv;
  assign bus.out_valid  = vld_q[S];
  assign bus.out_p      = acc_q[S];
  assign bus.out_tag    = tag_q[S];
  assign bus.out_signed = sgn_q[S];
endmodule

// File: tb/tb_pipe_mult_hs.sv
// tb/tb_pipe_mult_hs.sv - self-checking bench for pipe_mult_hs (4x4 BPS=1 and 8x8 BPS=2)
module tb_pipe_mult_hs;
  logic clk    = 1'b0;
  logic rst4_n = 1'b0;
  logic rst8_n = 1'b0;
  logic flush4 = 1'b0;
  logic flush8 = 1'b0;

  always #5 clk = ~clk;

  pipe_mult_hs_if #(.N(4), .M(4), .TAG_W(4)) b4 ();
  pipe_mult_hs_if #(.N(8), .M(8), .TAG_W(4)) b8 ();

  pipe_mult_hs #(.N(4), .M(4), .BPS(1), .TAG_W(4)) u4 (
    .clk(clk), .rst_n(rst4_n), .flush(flush4), .bus(b4)
  );
  pipe_mult_hs #(.N(8), .M(8), .BPS(2), .TAG_W(4)) u8 (
    .clk(clk), .rst_n(rst8_n), .flush(flush8), .bus(b8)
  );

  typedef struct {
    logic       s;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] tag;
    logic [7:0] p;
  } vec_t;

  typedef struct {
    logic [15:0] p;
    logic [3:0]  tag;
    logic        s;
    int          acc_cyc;
    int          stalls;
  } exp8_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic s, input int a, input int b,
                                           input int n, input int m);
    longint ia;
    longint ib;
    longint p;
    ia = a;
    ib = b;
    if (s && a >= (1 << (n - 1))) ia = a - (1 << n);
    if (s && b >= (1 << (m - 1))) ib = b - (1 << m);
    p = ia * ib;
    return p & ((64'd1 << (n + m)) - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive4(input logic v, input logic s, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] tag);
    b4.in_valid  = v;
    b4.in_signed = s;
    b4.in_a      = a;
    b4.in_b      = b;
    b4.in_tag    = tag;
  endtask

  task automatic run_single(input vec_t v, input string nm);
    int lat;
    b4.out_ready = 1'b1;
    drive4(1'b1, v.s, v.a, v.b, v.tag);
    tick();
    drive4(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    lat = 0;
    while (!b4.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({nm, " lat"}, lat, 4);
    chk({nm, " p"}, b4.out_p, v.p);
    chk({nm, " tag"}, b4.out_tag, v.tag);
    chk({nm, " signed"}, b4.out_signed, v.s);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tv [8];
    logic [7:0]  bp_p [6];
    exp8_t       q8 [$];
    exp8_t       e;
    int          got, issued, stall_left, seen, w, sent, cyc, stalls;
    logic        stall_seen, prev_hold, exp_rdy, s8;
    logic [7:0]  prev_p, a8, bb8;
    logic [3:0]  prev_tag;

    tv[0] = '{1'b0, 4'hF, 4'hF, 4'd3, 8'hE1};
    tv[1] = '{1'b1, 4'h8, 4'h8, 4'd1, 8'h40};
    tv[2] = '{1'b1, 4'hF, 4'h7, 4'd2, 8'hF9};
    tv[3] = '{1'b0, 4'hF, 4'h7, 4'd4, 8'h69};
    tv[4] = '{1'b1, 4'h7, 4'h8, 4'd5, 8'hC8};
    tv[5] = '{1'b0, 4'h0, 4'hF, 4'd6, 8'h00};
    tv[6] = '{1'b1, 4'h8, 4'h7, 4'd7, 8'hC8};
    tv[7] = '{1'b1, 4'hF, 4'hF, 4'd8, 8'h01};

    drive4(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    b4.out_ready = 1'b0;
    b8.in_valid = 1'b0; b8.in_signed = 1'b0; b8.in_a = '0; b8.in_b = '0; b8.in_tag = '0;
    b8.out_ready = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst4 out_valid", b4.out_valid, 0);
    chk("rst4 out_p", b4.out_p, 0);
    chk("rst4 out_tag", b4.out_tag, 0);
    chk("rst4 out_signed", b4.out_signed, 0);
    chk("rst4 in_ready", b4.in_ready, 1);
    chk("rst8 out_valid", b8.out_valid, 0);
    chk("rst8 out_p", b8.out_p, 0);
    rst4_n = 1'b1;
    rst8_n = 1'b1;
    tick();

    // table vectors, one at a time
    for (int i = 0; i < 8; i++) run_single(tv[i], $sformatf("vec%0d", i));

    // table vectors back to back, mixed modes
    got = 0;
    b4.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (b4.out_valid) begin
        if (got < 8) begin
          chk($sformatf("b2b%0d p", got), b4.out_p, tv[got].p);
          chk($sformatf("b2b%0d tag", got), b4.out_tag, tv[got].tag);
          chk($sformatf("b2b%0d signed", got), b4.out_signed, tv[got].s);
        end
        got++;
      end
      if (c < 8) drive4(1'b1, tv[c].s, tv[c].a, tv[c].b, tv[c].tag);
      else       drive4(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
      tick();
    end
    chk("b2b count", got, 8);

    // backpressure: 3-cycle stall once results start
    for (int i = 0; i < 6; i++) bp_p[i] = 8'(ref_prod(1'(i % 2), (i * 3 + 1) % 16, 15 - i * 2, 4, 4));
    got = 0; issued = 0; stall_left = 0; stall_seen = 1'b0; prev_hold = 1'b0;
    prev_p = '0; prev_tag = '0;
    for (int c = 0; c < 40; c++) begin
      if (b4.out_valid && !stall_seen) begin
        stall_seen = 1'b1;
        stall_left = 3;
      end
      b4.out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      exp_rdy = !b4.out_valid || b4.out_ready;
      chk("bp in_ready", b4.in_ready, exp_rdy);
      if (prev_hold) begin
        chk("bp hold p", b4.out_p, prev_p);
        chk("bp hold tag", b4.out_tag, prev_tag);
      end
      prev_hold = b4.out_valid && !b4.out_ready;
      prev_p    = b4.out_p;
      prev_tag  = b4.out_tag;
      if (b4.out_valid && b4.out_ready) begin
        if (got < 6) begin
          chk($sformatf("bp%0d p", got), b4.out_p, bp_p[got]);
          chk($sformatf("bp%0d tag", got), b4.out_tag, got);
        end else begin
          chk("bp extra result", got, 5);
        end
        got++;
      end
      if (issued < 6 && exp_rdy) begin
        drive4(1'b1, 1'(issued % 2), 4'(issued * 3 + 1), 4'(15 - issued * 2), 4'(issued));
        issued++;
      end else begin
        drive4(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
      end
      tick();
    end
    chk("bp count", got, 6);
    chk("bp stall happened", stall_seen, 1);

    // flush with three in flight plus a same-cycle accept
    b4.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive4(1'b1, 1'b0, 4'(i + 5), 4'(i + 2), 4'(10 + i));
      tick();
    end
    flush4 = 1'b1;
    drive4(1'b1, 1'b1, 4'hF, 4'hF, 4'd13);
    tick();
    flush4 = 1'b0;
    chk("flush out_valid", b4.out_valid, 0);
    drive4(1'b1, 1'b1, 4'h9, 4'h3, 4'd9);
    tick();
    drive4(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (b4.out_valid) begin
        seen++;
        chk("flush tag", b4.out_tag, 9);
        chk("flush p", b4.out_p, 8'hEB);
        chk("flush lat", c, 4);
      end
      tick();
    end
    chk("flush count", seen, 1);

    // asynchronous reset with a stalled result and one behind it
    b4.out_ready = 1'b0;
    drive4(1'b1, 1'b1, 4'h5, 4'hB, 4'd7);
    tick();
    drive4(1'b1, 1'b0, 4'h3, 4'h3, 4'd8);
    tick();
    drive4(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    w = 0;
    while (!b4.out_valid && w < 20) begin
      tick();
      w++;
    end
    chk("rst pre valid", b4.out_valid, 1);
    chk("rst pre p", b4.out_p, 8'hE7);
    #2 rst4_n = 1'b0;
    #1;
    chk("rst async out_valid", b4.out_valid, 0);
    chk("rst async out_p", b4.out_p, 0);
    chk("rst async out_tag", b4.out_tag, 0);
    chk("rst async out_signed", b4.out_signed, 0);
    tick();
    rst4_n = 1'b1;
    b4.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (b4.out_valid) seen++;
      tick();
    end
    chk("rst no stale result", seen, 0);

    // randomized 8x8 BPS=2 against the arithmetic model
    sent = 0; cyc = 0; stalls = 0;
    while ((sent < 1000 || q8.size() > 0) && cyc < 20000) begin
      b8.out_ready = ($urandom_range(0, 9) < 7);
      #1;
      exp_rdy = !b8.out_valid || b8.out_ready;
      chk("rnd in_ready", b8.in_ready, exp_rdy);
      if (b8.out_valid && b8.out_ready) begin
        if (q8.size() == 0) begin
          chk("rnd spurious result", 1, 0);
        end else begin
          e = q8.pop_front();
          chk("rnd p", b8.out_p, e.p);
          chk("rnd tag", b8.out_tag, e.tag);
          chk("rnd signed", b8.out_signed, e.s);
          if (e.stalls == stalls) chk("rnd lat", cyc - e.acc_cyc - 1, 4);
        end
      end
      if (b8.out_valid && !b8.out_ready) stalls++;
      if (sent < 1000 && exp_rdy && $urandom_range(0, 4) != 0) begin
        if (sent == 0) begin
          s8 = 1'b1; a8 = 8'h80; bb8 = 8'h80;
        end else if (sent == 1) begin
          s8 = 1'b0; a8 = 8'hFF; bb8 = 8'hFF;
        end else begin
          s8 = 1'($urandom_range(0, 1)); a8 = 8'($urandom); bb8 = 8'($urandom);
        end
        b8.in_valid  = 1'b1;
        b8.in_signed = s8;
        b8.in_a      = a8;
        b8.in_b      = bb8;
        b8.in_tag    = 4'(sent);
        if (sent == 0)      e.p = 16'h4000;
        else if (sent == 1) e.p = 16'hFE01;
        else                e.p = 16'(ref_prod(s8, int'(a8), int'(bb8), 8, 8));
        e.tag = 4'(sent); e.s = s8; e.acc_cyc = cyc; e.stalls = stalls;
        q8.push_back(e);
        sent++;
      end else begin
        b8.in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    chk("rnd all delivered", 1000 - sent + q8.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
